// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and shared helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  localparam int unsigned DIV_ITERS = 32;

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  function automatic logic [63:0] div_fixup(input logic [31:0] q_mag,
                                            input logic [31:0] r_mag,
                                            input logic        a_neg,
                                            input logic        b_neg);
    logic [31:0] q;
    logic [31:0] r;
    q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r = a_neg ? (32'd0 - r_mag) : r_mag;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage request/stall/result signals between pipeline and MDU.
interface mdu_hilo_if;
  logic        ex_valid;
  logic [2:0]  ex_mdop;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_hold;
  logic        ex_refresh;
  logic        mdu_stall_req;
  logic        mdu_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_valid, ex_mdop, ex_a, ex_b, ex_hold, ex_refresh,
    input  mdu_stall_req, mdu_busy, hi, lo
  );

  modport slave (
    input  ex_valid, ex_mdop, ex_a, ex_b, ex_hold, ex_refresh,
    output mdu_stall_req, mdu_busy, hi, lo
  );
endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: radix-2 restoring divider on 32-bit magnitudes, one bit per cycle.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a_abs,
  input  logic [31:0] b_abs,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);
  localparam int unsigned CW = $clog2(DIV_ITERS);

  logic          running;
  logic [CW-1:0] cnt;
  logic [31:0]   rem, quo, dvs;
  logic [32:0]   diff;
  logic          take;
  logic [31:0]   rem_nx, quo_nx;

  // q/r present this cycle's iteration result so the final step can be captured directly.
  always_comb begin
    diff   = {rem, quo[31]} - {1'b0, dvs};
    take   = ~diff[32];
    rem_nx = take ? diff[31:0] : {rem[30:0], quo[31]};
    quo_nx = {quo[30:0], take};
    done   = running && (cnt == CW'(DIV_ITERS - 1));
    q      = quo_nx;
    r      = rem_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= a_abs;
      dvs     <= b_abs;
    end else if (running) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with EX stall/refresh handshake.
// Define MDU_DIV_EARLY_EN to finish divide-by-zero and |a|<|b| divides on the issue cycle.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic      clk,
  input  logic      resetn,
  mdu_hilo_if.slave bus
);
  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  mdu_state_t  state;
  logic [3:0]  mul_cnt;
  logic [31:0] hi_q, lo_q, hi_r, lo_r;
  logic        sa, sb;

  logic        is_md, is_mul, is_sgn, issue, mt_write;
  logic        a_neg, b_neg, div_early, div_start, div_abort, div_done;
  logic [31:0] a_abs, b_abs, early_q, div_q, div_r;
  logic [63:0] mul_res;

  always_comb begin
    is_md    = bus.ex_mdop inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};
    is_mul   = (bus.ex_mdop == MDOP_MULT) || (bus.ex_mdop == MDOP_MULTU);
    is_sgn   = (bus.ex_mdop == MDOP_MULT) || (bus.ex_mdop == MDOP_DIV);
    issue    = (state == ST_IDLE) && bus.ex_valid && is_md && !bus.ex_refresh;
    mt_write = bus.ex_valid && !bus.ex_hold && !bus.ex_refresh &&
               ((bus.ex_mdop == MDOP_MTHI) || (bus.ex_mdop == MDOP_MTLO));
    a_neg    = is_sgn && bus.ex_a[31];
    b_neg    = is_sgn && bus.ex_b[31];
    a_abs    = a_neg ? (32'd0 - bus.ex_a) : bus.ex_a;
    b_abs    = b_neg ? (32'd0 - bus.ex_b) : bus.ex_b;
    early_q  = (b_abs == '0) ? '1 : '0;
    // Operands are widened first so one 64x64 product serves both signednesses.
    mul_res  = is_sgn ? ({{32{bus.ex_a[31]}}, bus.ex_a} * {{32{bus.ex_b[31]}}, bus.ex_b})
                      : ({32'd0, bus.ex_a} * {32'd0, bus.ex_b});
  end

`ifdef MDU_DIV_EARLY_EN
  assign div_early = (b_abs == '0) || (a_abs < b_abs);
`else
  assign div_early = 1'b0;
`endif

  assign div_start = issue && !is_mul && !div_early;
  assign div_abort = (state == ST_DIV) && bus.ex_refresh;

  mdu_div_core u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (div_start),
    .abort  (div_abort),
    .a_abs  (a_abs),
    .b_abs  (b_abs),
    .done   (div_done),
    .q      (div_q),
    .r      (div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            if (is_mul) begin
              {hi_r, lo_r} <= mul_res;
              mul_cnt      <= 4'd1;
              if (MUL_LAT <= 1) state <= ST_DONE;
              else              state <= ST_MUL;
            end else begin
              sa <= a_neg;
              sb <= b_neg;
              if (div_early) begin
                {hi_r, lo_r} <= div_fixup(early_q, a_abs, a_neg, b_neg);
                state        <= ST_DONE;
              end else begin
                state <= ST_DIV;
              end
            end
          end else if (mt_write) begin
            if (bus.ex_mdop == MDOP_MTHI) hi_q <= bus.ex_a;
            else                          lo_q <= bus.ex_a;
          end
        end
        ST_MUL: begin
          if (bus.ex_refresh)           state   <= ST_IDLE;
          else if (mul_cnt == MUL_LAST) state   <= ST_DONE;
          else                          mul_cnt <= mul_cnt + 4'd1;
        end
        ST_DIV: begin
          if (bus.ex_refresh) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            {hi_r, lo_r} <= div_fixup(div_q, div_r, sa, sb);
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.ex_refresh) begin
            state <= ST_IDLE;
          end else if (!bus.ex_hold) begin
            hi_q  <= hi_r;
            lo_q  <= lo_r;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.mdu_stall_req = bus.ex_valid && is_md && (state != ST_DONE);
  assign bus.mdu_busy      = (state != ST_IDLE);
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed plus randomized ops checked against an arithmetic HI/LO reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_if bus();

  mdu_hilo #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {hi, lo} an op must leave behind, from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa_, sb_, q, r;
    longint unsigned ua, ub;
    sa_ = longint'(int'(a));
    sb_ = longint'(int'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      MDOP_MULT:  return 64'(sa_ * sb_);
      MDOP_MULTU: return ua * ub;
      MDOP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) return {a, (sa_ < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
        q = sa_ / sb_;
        r = sa_ % sb_;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  function automatic int unsigned ref_stalls(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint ma, mb;
    if (op == MDOP_MULT || op == MDOP_MULTU) return MUL_LAT;
    if (op == MDOP_DIV) begin
      ma = longint'(int'(a)); if (ma < 0) ma = -ma;
      mb = longint'(int'(b)); if (mb < 0) mb = -mb;
    end else begin
      ma = longint'({32'd0, a});
      mb = longint'({32'd0, b});
    end
`ifdef MDU_DIV_EARLY_EN
    if (mb == 0 || ma < mb) return 1;
`else
    if (mb < 0 || ma < 0) return 0;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic idle_inputs();
    bus.ex_valid   = 1'b0;
    bus.ex_mdop    = MDOP_NONE;
    bus.ex_hold    = 1'b0;
    bus.ex_refresh = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires or flushes the op.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned hold_extra, input int unsigned flush_at);
    int unsigned stalls = 0, held = 0, cyc = 0, exp_st;
    logic        fin = 1'b0, flushed = 1'b0, commit;
    logic [63:0] res;
    exp_st = ref_stalls(op, a, b);
    res    = ref_md(op, a, b);
    bus.ex_valid   = 1'b1;
    bus.ex_mdop    = op;
    bus.ex_a       = a;
    bus.ex_b       = b;
    bus.ex_refresh = 1'b0;
    while (!fin && cyc < 100) begin
      #1;
      cyc++;
      commit = 1'b0;
      if (flush_at != 0 && cyc == flush_at) begin
        bus.ex_refresh = 1'b1;
        bus.ex_hold    = 1'b0;
        flushed        = 1'b1;
      end else if (bus.mdu_stall_req) begin
        stalls++;
        bus.ex_hold = 1'b1;
      end else if (held < hold_extra) begin
        held++;
        bus.ex_hold = 1'b1;
        check("held_lo", bus.lo, m_lo);
      end else begin
        bus.ex_hold = 1'b0;
        commit      = 1'b1;
      end
      @(posedge clk);
      #1;
      if (flushed || commit) begin
        fin = 1'b1;
        idle_inputs();
      end
    end
    check("finished", fin, 1);
    if (flushed) begin
      check("flush_busy", bus.mdu_busy, 0);
    end else begin
      check("stalls", stalls, exp_st);
      check("busy", bus.mdu_busy, 0);
      m_hi = res[63:32];
      m_lo = res[31:0];
    end
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input int unsigned holds,
                       input logic flush);
    bus.ex_valid = 1'b1;
    bus.ex_mdop  = op;
    bus.ex_a     = a;
    bus.ex_b     = 32'($urandom);
    for (int unsigned i = 0; i < holds; i++) begin
      bus.ex_hold = 1'b1;
      #1;
      check("mt_stall", bus.mdu_stall_req, 0);
      @(posedge clk);
      #1;
      check("mt_hold_hi", bus.hi, m_hi);
      check("mt_hold_lo", bus.lo, m_lo);
    end
    bus.ex_hold    = 1'b0;
    bus.ex_refresh = flush;
    @(posedge clk);
    #1;
    if (!flush) begin
      if (op == MDOP_MTHI) m_hi = a;
      else                 m_lo = a;
    end
    idle_inputs();
    check("mt_hi", bus.hi, m_hi);
    check("mt_lo", bus.lo, m_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int unsigned fa;

    bus.ex_a = '0;
    bus.ex_b = '0;
    idle_inputs();
    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.mdu_busy, 0);
    check("rst_stall", bus.mdu_stall_req, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    do_md(MDOP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
    do_md(MDOP_DIVU, 32'h0000_0064, 32'h0000_0007, 0, 0);
    do_md(MDOP_DIV,  32'hFFFF_FF9C, 32'h0000_0007, 0, 0);
    do_md(MDOP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 0, 0);
    do_md(MDOP_DIVU, 32'h1234_5678, 32'h0000_0000, 0, 0);
    do_md(MDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_md(MDOP_DIV,  32'h0000_0005, 32'hFFFF_FFF9, 0, 0);

    do_mt(MDOP_MTHI, 32'h1234_5678, 0, 1'b0);
    do_mt(MDOP_MTLO, 32'h9ABC_DEF0, 0, 1'b0);
    do_md(MDOP_DIV, 32'h0000_03E8, 32'h0000_0003, 0, 10);
    do_md(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
    do_md(MDOP_MULT, 32'h0000_0007, 32'hFFFF_FFF7, 3, 0);

    do_mt(MDOP_MTLO, 32'hCAFE_BABE, 2, 1'b0);
    do_mt(MDOP_MTHI, 32'h5555_5555, 0, 1'b1);

    // Asynchronous reset in the middle of a divide.
    bus.ex_valid = 1'b1;
    bus.ex_mdop  = MDOP_DIV;
    bus.ex_a     = 32'h7000_0000;
    bus.ex_b     = 32'h0000_0003;
    bus.ex_hold  = 1'b1;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", bus.mdu_busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    m_hi = '0;
    m_lo = '0;
    idle_inputs();
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = pick();
      b  = pick();
      if (op == MDOP_MTHI || op == MDOP_MTLO) begin
        do_mt(op, a, $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
      end else begin
        fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, ref_stalls(op, a, b) + 1) : 0;
        do_md(op, a, b, $urandom_range(0, 3), fa);
      end
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
